// File: rtl/return_address_stack_pkg.sv
// Shared fetch-unit types for the return address stack.
//   RAS_ENTRY_NUM / RAS_ENTRY_NUM_BIT_WIDTH : stack depth and index width
//   INSN_BYTE_WIDTH                         : return address = call PC + this
//   RAS_IndexPath / RAS_CountPath           : stack pointer and occupancy types
//   RAS_CheckpointPath                      : {tos, count, topAddr} snapshot
//   BranchPred                              : per-insn prediction, carries the RAS checkpoint
package return_address_stack_pkg;

  localparam int PC_W                    = 32;
  localparam int RAS_ENTRY_NUM           = 8;
  localparam int RAS_ENTRY_NUM_BIT_WIDTH = $clog2(RAS_ENTRY_NUM);
  localparam int INSN_BYTE_WIDTH         = 4;

  typedef logic [PC_W-1:0]                    PC_Path;
  typedef logic [RAS_ENTRY_NUM_BIT_WIDTH-1:0] RAS_IndexPath;
  // One extra bit so a full stack (count == RAS_ENTRY_NUM) is representable.
  typedef logic [RAS_ENTRY_NUM_BIT_WIDTH:0]   RAS_CountPath;

  typedef struct packed {
    RAS_IndexPath tos;
    RAS_CountPath count;
    PC_Path       topAddr;
  } RAS_CheckpointPath;

  typedef struct packed {
    logic              taken;
    PC_Path            target;
    RAS_CheckpointPath rasCkpt;
  } BranchPred;

  // Link address pushed by a call: the insn following it, wrapping mod 2^PC_W.
  function automatic PC_Path ReturnAddr(input PC_Path pc);
    return pc + PC_Path'(INSN_BYTE_WIDTH);
  endfunction

endpackage

// File: rtl/return_address_stack_if.sv
// Fetch/decode <-> return address stack connection.
//   master : fetch + resolver side (drives fetch candidates and recovery)
//   slave  : the stack (drives prediction and checkpoint)
interface return_address_stack_if;
  import return_address_stack_pkg::*;

  logic              stall;
  logic              fetchValid;
  logic              fetchIsCall;
  logic              fetchIsReturn;
  PC_Path            fetchPC;
  logic              predValid;
  PC_Path            predAddr;
  RAS_CheckpointPath checkpoint;
  logic              recover;
  RAS_CheckpointPath recoverCkpt;
  logic              recoverIsCall;
  logic              recoverIsRet;
  PC_Path            recoverPC;

  modport master (
    output stall, fetchValid, fetchIsCall, fetchIsReturn, fetchPC,
    output recover, recoverCkpt, recoverIsCall, recoverIsRet, recoverPC,
    input  predValid, predAddr, checkpoint
  );

  modport slave (
    input  stall, fetchValid, fetchIsCall, fetchIsReturn, fetchPC,
    input  recover, recoverCkpt, recoverIsCall, recoverIsRet, recoverPC,
    output predValid, predAddr, checkpoint
  );
endinterface

// File: rtl/return_address_stack_ras_entry_array.sv
// RAS storage: RAS_ENTRY_NUM x PC_W register file, one write port and one
// asynchronous read port (the top of stack). Entries are not reset.
//   clk        : clock
//   writeEnable: commit writeData to entry[writeIndex] at the clock edge
//   writeIndex : entry to write
//   writeData  : value to write
//   readIndex  : entry to read
//   readData   : entry[readIndex], combinational
module ras_entry_array
  import return_address_stack_pkg::*;
(
  input  logic         clk,
  input  logic         writeEnable,
  input  RAS_IndexPath writeIndex,
  input  PC_Path       writeData,
  input  RAS_IndexPath readIndex,
  output PC_Path       readData
);

  PC_Path entryReg [RAS_ENTRY_NUM];

  always_ff @(posedge clk) begin
    if (writeEnable) begin
      entryReg[writeIndex] <= writeData;
    end
  end

  assign readData = entryReg[readIndex];

endmodule

// File: rtl/return_address_stack.sv
// Fetch-side return address stack. Predicts return targets, exports a
// checkpoint of its pre-update state for every fetched insn, and rolls back
// to such a checkpoint when the resolver flushes.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : slave side of return_address_stack_if (fetch inputs, recovery
//         inputs, predValid/predAddr/checkpoint outputs)
module return_address_stack
  import return_address_stack_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  return_address_stack_if.slave bus
);

  localparam RAS_CountPath FULL_COUNT = RAS_CountPath'(RAS_ENTRY_NUM);
  localparam RAS_IndexPath ONE_INDEX  = RAS_IndexPath'(1);

  RAS_IndexPath tosReg, tosNext;
  RAS_CountPath countReg, countNext;
  PC_Path       topAddr;

  logic         writeEnable;
  RAS_IndexPath writeIndex;
  PC_Path       writeData;

  logic         doPush, doPop;
  RAS_IndexPath baseTos;
  RAS_CountPath baseCount;
  logic         opCall, opRet;
  PC_Path       opPC;
  PC_Path       retAddr;

  ras_entry_array entryArray (
    .clk        (clk),
    .writeEnable(writeEnable),
    .writeIndex (writeIndex),
    .writeData  (writeData),
    .readIndex  (tosReg),
    .readData   (topAddr)
  );

  // Recovery restores {tos,count,entry[tos]} from the checkpoint and then
  // replays the flushing insn's own effect. Both normal fetch and recovery
  // therefore reduce to "apply op to a base state"; only the base differs.
  // The restore write and the op's write collapse into one physical write:
  //   - no op / pop : restore entry[ckpt.tos]
  //   - push        : write ckpt.tos+1; the restore is dropped since
  //                   ckpt.tos is no longer the top afterwards
  //   - replace     : write ckpt.tos with the new link address
  always_comb begin
    doPush      = bus.fetchValid & bus.fetchIsCall   & ~bus.stall;
    doPop       = bus.fetchValid & bus.fetchIsReturn & ~bus.stall;

    baseTos     = tosReg;
    baseCount   = countReg;
    opCall      = doPush;
    opRet       = doPop;
    opPC        = bus.fetchPC;
    if (bus.recover) begin
      baseTos   = bus.recoverCkpt.tos;
      baseCount = bus.recoverCkpt.count;
      opCall    = bus.recoverIsCall;
      opRet     = bus.recoverIsRet;
      opPC      = bus.recoverPC;
    end
    retAddr     = ReturnAddr(opPC);

    tosNext     = baseTos;
    countNext   = baseCount;
    writeEnable = bus.recover & ~rst;
    writeIndex  = bus.recoverCkpt.tos;
    writeData   = bus.recoverCkpt.topAddr;

    if (opCall && opRet) begin
      // Coroutine JALR: swap the top in place.
      writeEnable = ~rst;
      writeIndex  = baseTos;
      writeData   = retAddr;
      if (baseCount == '0) begin
        countNext = RAS_CountPath'(1);
      end
    end else if (opCall) begin
      // Overflow wraps and overwrites the oldest entry.
      tosNext     = baseTos + ONE_INDEX;
      writeEnable = ~rst;
      writeIndex  = baseTos + ONE_INDEX;
      writeData   = retAddr;
      countNext   = (baseCount >= FULL_COUNT) ? FULL_COUNT : baseCount + RAS_CountPath'(1);
    end else if (opRet) begin
      // Underflow still moves tos so that push/pop pairs stay aligned.
      tosNext   = baseTos - ONE_INDEX;
      countNext = (baseCount == '0) ? '0 : baseCount - RAS_CountPath'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tosReg   <= '0;
      countReg <= '0;
    end else begin
      tosReg   <= tosNext;
      countReg <= countNext;
    end
  end

  assign bus.predValid          = (countReg != '0);
  assign bus.predAddr           = bus.predValid ? topAddr : '0;
  assign bus.checkpoint.tos     = tosReg;
  assign bus.checkpoint.count   = countReg;
  assign bus.checkpoint.topAddr = topAddr;

endmodule

// File: tb/tb_return_address_stack.sv
module tb_return_address_stack;
  import return_address_stack_pkg::*;

  localparam int N = RAS_ENTRY_NUM;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  return_address_stack_if bus();

  return_address_stack dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int vectors    = 0;
  int miscompares = 0;
  bit checkEn    = 1'b0;

  // Abstract model: circular stack of link addresses with a saturating count.
  int          mTos   = 0;
  int          mCount = 0;
  logic [31:0] mEntry [N];
  bit          mKnown [N];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic mApply(input bit isCall, input bit isRet, input logic [31:0] pc);
    if (isCall && isRet) begin
      mEntry[mTos] = pc + 32'd4;
      mKnown[mTos] = 1'b1;
      if (mCount == 0) mCount = 1;
    end else if (isCall) begin
      mTos = (mTos + 1) % N;
      mEntry[mTos] = pc + 32'd4;
      mKnown[mTos] = 1'b1;
      mCount = (mCount < N) ? mCount + 1 : N;
    end else if (isRet) begin
      mTos = (mTos + N - 1) % N;
      mCount = (mCount > 0) ? mCount - 1 : 0;
    end
  endtask

  // One clock: the model takes the effect of whatever inputs are presented.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      mTos   = 0;
      mCount = 0;
    end else if (bus.recover) begin
      mTos   = int'(bus.recoverCkpt.tos);
      mCount = int'(bus.recoverCkpt.count);
      // A pure push leaves the restored slot below the top; it is not rewritten.
      if (!(bus.recoverIsCall && !bus.recoverIsRet)) begin
        mEntry[mTos] = bus.recoverCkpt.topAddr;
        mKnown[mTos] = 1'b1;
      end
      mApply(bus.recoverIsCall, bus.recoverIsRet, bus.recoverPC);
    end else if (bus.fetchValid && !bus.stall) begin
      mApply(bus.fetchIsCall, bus.fetchIsReturn, bus.fetchPC);
    end
    #1;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      chk("cyc_predValid", 64'(bus.predValid), 64'(mCount != 0));
      chk("cyc_predAddr", 64'(bus.predAddr), (mCount != 0) ? 64'(mEntry[mTos]) : 64'd0);
      chk("cyc_tos", 64'(bus.checkpoint.tos), 64'(mTos));
      chk("cyc_count", 64'(bus.checkpoint.count), 64'(mCount));
      if (mKnown[mTos]) chk("cyc_topAddr", 64'(bus.checkpoint.topAddr), 64'(mEntry[mTos]));
    end
  end

  task automatic clearInputs();
    bus.stall         = 1'b0;
    bus.fetchValid    = 1'b0;
    bus.fetchIsCall   = 1'b0;
    bus.fetchIsReturn = 1'b0;
    bus.fetchPC       = '0;
    bus.recover       = 1'b0;
    bus.recoverCkpt   = '0;
    bus.recoverIsCall = 1'b0;
    bus.recoverIsRet  = 1'b0;
    bus.recoverPC     = '0;
  endtask

  task automatic doReset();
    clearInputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic fetch(input bit isCall, input bit isRet, input logic [31:0] pc, input bit st);
    bus.fetchValid    = 1'b1;
    bus.fetchIsCall   = isCall;
    bus.fetchIsReturn = isRet;
    bus.fetchPC       = pc;
    bus.stall         = st;
    tick();
    clearInputs();
  endtask

  task automatic doRecover(input RAS_CheckpointPath ck, input bit isCall, input bit isRet,
                           input logic [31:0] pc, input bit fCall, input logic [31:0] fpc,
                           input bit st);
    bus.recover       = 1'b1;
    bus.recoverCkpt   = ck;
    bus.recoverIsCall = isCall;
    bus.recoverIsRet  = isRet;
    bus.recoverPC     = pc;
    bus.fetchValid    = fCall;
    bus.fetchIsCall   = fCall;
    bus.fetchPC       = fpc;
    bus.stall         = st;
    tick();
    clearInputs();
  endtask

  RAS_CheckpointPath ck;

  initial begin
    for (int i = 0; i < N; i++) mKnown[i] = 1'b0;
    clearInputs();

    // 1. Reset state.
    doReset();
    checkEn = 1'b1;
    chk("rst_predValid", 64'(bus.predValid), 64'd0);
    chk("rst_predAddr", 64'(bus.predAddr), 64'd0);
    chk("rst_tos", 64'(bus.checkpoint.tos), 64'd0);
    chk("rst_count", 64'(bus.checkpoint.count), 64'd0);

    // 2. Two calls, two returns.
    fetch(1, 0, 32'h1000, 0);
    fetch(1, 0, 32'h2000, 0);
    chk("s2_top2", 64'(bus.predAddr), 64'h2004);
    fetch(0, 1, 32'h2100, 0);
    chk("s2_top1", 64'(bus.predAddr), 64'h1004);
    fetch(0, 1, 32'h1100, 0);
    chk("s2_empty", 64'(bus.predValid), 64'd0);

    // 3. Overflow: 9 calls into 8 entries, then drain.
    doReset();
    for (int k = 1; k <= 9; k++) fetch(1, 0, 32'(k * 32'h100), 0);
    chk("s3_count", 64'(bus.checkpoint.count), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk("s3_pop", 64'(bus.predAddr), 64'((9 - i) * 32'h100 + 32'h4));
      fetch(0, 1, 32'hF000, 0);
    end
    chk("s3_drained", 64'(bus.predValid), 64'd0);
    fetch(0, 1, 32'hF000, 0);
    chk("s3_underflow_valid", 64'(bus.predValid), 64'd0);
    chk("s3_underflow_count", 64'(bus.checkpoint.count), 64'd0);

    // Pop on empty still moves tos; next push lands above it.
    doReset();
    fetch(0, 1, 32'hF000, 0);
    chk("empty_pop_tos", 64'(bus.checkpoint.tos), 64'd7);
    fetch(1, 0, 32'hA000, 0);
    chk("empty_pop_push_tos", 64'(bus.checkpoint.tos), 64'd0);
    chk("empty_pop_push_addr", 64'(bus.predAddr), 64'hA004);

    // 4. Wrong-path pop + push repaired by recovery.
    doReset();
    fetch(1, 0, 32'h1000, 0);
    ck = bus.checkpoint;
    chk("s4_ckpt", 64'(ck), 64'({3'd1, 4'd1, 32'h1004}));
    fetch(0, 1, 32'h1100, 0);
    fetch(1, 0, 32'h5000, 0);
    chk("s4_wrongpath", 64'(bus.predAddr), 64'h5004);
    ck = '{tos: 3'd1, count: 4'd1, topAddr: 32'h1004};
    doRecover(ck, 0, 0, 32'h0, 0, 32'h0, 0);
    chk("s4_addr", 64'(bus.predAddr), 64'h1004);
    chk("s4_count", 64'(bus.checkpoint.count), 64'd1);

    // 5. Recovery beats a same-cycle fetch push.
    doRecover(ck, 1, 0, 32'h3000, 1, 32'h7000, 0);
    chk("s5_addr", 64'(bus.predAddr), 64'h3004);
    chk("s5_count", 64'(bus.checkpoint.count), 64'd2);
    fetch(0, 1, 32'h3100, 0);
    chk("s5_below", 64'(bus.predAddr), 64'h1004);

    // 6. Stall suppresses fetch; recovery ignores stall; replace on empty.
    fetch(1, 0, 32'h8000, 1);
    chk("s6_stall_addr", 64'(bus.predAddr), 64'h1004);
    chk("s6_stall_count", 64'(bus.checkpoint.count), 64'd1);
    doRecover(ck, 0, 1, 32'h1100, 0, 32'h0, 1);
    chk("s6_recover_stalled", 64'(bus.predValid), 64'd0);
    chk("s6_recover_tos", 64'(bus.checkpoint.tos), 64'd0);
    doReset();
    fetch(1, 1, 32'h4000, 0);
    chk("s6_replace_addr", 64'(bus.predAddr), 64'h4004);
    chk("s6_replace_count", 64'(bus.checkpoint.count), 64'd1);
    fetch(1, 1, 32'h4800, 0);
    chk("s6_replace_again", 64'(bus.predAddr), 64'h4804);
    chk("s6_replace_count2", 64'(bus.checkpoint.count), 64'd1);

    // PC wrap on push.
    fetch(1, 0, 32'hFFFF_FFFE, 0);
    chk("wrap_addr", 64'(bus.predAddr), 64'h2);

    // Reset wins over a simultaneous recovery.
    bus.recover       = 1'b1;
    bus.recoverCkpt   = '{tos: 3'd5, count: 4'd3, topAddr: 32'hBEEF};
    bus.recoverIsCall = 1'b1;
    bus.recoverPC     = 32'h6000;
    rst = 1'b1;
    tick();
    clearInputs();
    rst = 1'b0;
    chk("rst_recover_valid", 64'(bus.predValid), 64'd0);
    chk("rst_recover_tos", 64'(bus.checkpoint.tos), 64'd0);
    chk("rst_recover_count", 64'(bus.checkpoint.count), 64'd0);

    tick();
    tick();
    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
